// File: rtl/alu_pkg.sv
// alu_pkg: opcodes shared with the ALU select logic and the overflow interrupt FSM encoding.
package alu_pkg;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    typedef enum logic [1:0] {
        IRQ_IDLE = 2'd0,
        IRQ_REQ  = 2'd1,
        IRQ_ACK  = 2'd2
    } irq_state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter; a clear that coincides with an increment loads 1.
module sat_counter #(
    parameter int W = 4
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Clr,
    input  logic         Inc,
    output logic [W-1:0] Count
);
    logic [W-1:0] r_count;
    always_ff @(posedge Clk)
        if (Reset)
            r_count <= '0;
        else if (Clr)
            r_count <= W'(Inc);
        else if (Inc && r_count != '1)
            r_count <= r_count + 1'b1;
    assign Count = r_count;
endmodule

// File: rtl/alu_overflow_monitor.sv
// alu_overflow_monitor: registers Z/N/V status after the ALU, tracks sticky overflow,
// counts overflow events and raises a four-phase overflow interrupt.
module alu_overflow_monitor
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Valid,
    input  logic [2:0]       Sel,
    input  logic             Overflow,
    input  logic [WIDTH-1:0] Result,
    input  logic             IrqEn,
    input  logic             StatClr,
    input  logic             IrqAck,
    output logic             FlagZ,
    output logic             FlagN,
    output logic             FlagV,
    output logic             StickyV,
    output logic [CNT_W-1:0] OvfCount,
    output logic             Irq,
    output logic             Missed
);
    logic       w_ovf_evt, w_miss_evt;
    logic       r_z, r_n, r_v, r_sticky, r_missed;
    irq_state_t r_state, w_next;
    assign w_ovf_evt  = Valid & Overflow & (Sel == OP_ADD | Sel == OP_SUB);
    assign w_miss_evt = w_ovf_evt & (r_state != IRQ_IDLE);
    always_ff @(posedge Clk)
        if (Reset) begin
            r_z <= 1'b0;
            r_n <= 1'b0;
            r_v <= 1'b0;
        end else if (Valid) begin
            r_z <= Result == '0;
            r_n <= Result[WIDTH-1];
            r_v <= w_ovf_evt;
        end
    // A new event in the clear cycle survives the clear.
    always_ff @(posedge Clk)
        if (Reset) begin
            r_sticky <= 1'b0;
            r_missed <= 1'b0;
        end else begin
            r_sticky <= w_ovf_evt | (r_sticky & ~StatClr);
            r_missed <= w_miss_evt | (r_missed & ~StatClr);
        end
    sat_counter #(.W(CNT_W)) u_cnt (
        .Clk  (Clk),
        .Reset(Reset),
        .Clr  (StatClr),
        .Inc  (w_ovf_evt),
        .Count(OvfCount)
    );
    always_ff @(posedge Clk)
        if (Reset)
            r_state <= IRQ_IDLE;
        else
            r_state <= w_next;
    always_comb begin
        w_next = r_state;
        case (r_state)
            IRQ_IDLE: w_next = (w_ovf_evt & IrqEn) ? IRQ_REQ : IRQ_IDLE;
            IRQ_REQ:  w_next = IrqAck ? IRQ_ACK : IRQ_REQ;
            IRQ_ACK:  w_next = IrqAck ? IRQ_ACK : IRQ_IDLE;
            default:  w_next = IRQ_IDLE;
        endcase
    end
    always_comb begin
        Irq = r_state == IRQ_REQ;
    end
    assign FlagZ   = r_z;
    assign FlagN   = r_n;
    assign FlagV   = r_v;
    assign StickyV = r_sticky;
    assign Missed  = r_missed;
endmodule

// File: doc/alu_overflow_monitor.md
Name: alu_overflow_monitor

Overview:
- Consumer end of the ALU overflow path.
- Registers the per-operation overflow bit produced for add/sub, together with result-derived Z/N flags, into a status word.
- Keeps a sticky overflow bit and a saturating overflow event counter.
- Raises a four-phase request/acknowledge overflow interrupt toward the controller.
- Sits directly after the ALU datapath, between the ALU and the control/exception logic.

Parameters:
- WIDTH, 8, ALU result width in bits.
- CNT_W, 4, width of the saturating overflow event counter.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Valid  input  1  ALU result, Sel and Overflow are valid this cycle.
- Sel  input  3  ALU opcode: 3'b000 add, 3'b001 sub, all others non-arithmetic.
- Overflow  input  1  signed overflow bit for the current operation.
- Result  input  WIDTH  ALU result, used for the Z and N flags.
- IrqEn  input  1  enables interrupt generation.
- StatClr  input  1  single-cycle pulse; clears StickyV, OvfCount and Missed.
- IrqAck  input  1  interrupt acknowledge, four-phase.
- FlagZ  output  1  registered: Result == 0.
- FlagN  output  1  registered: Result[WIDTH-1].
- FlagV  output  1  registered overflow of the last valid operation.
- StickyV  output  1  set by any overflow since the last clear.
- OvfCount  output  CNT_W  saturating count of overflow events.
- Irq  output  1  interrupt request.
- Missed  output  1  an overflow occurred while a request was outstanding.

Behaviour:
- Reset: all outputs 0 on the first rising edge with Reset=1; FSM to IDLE. Reset overrides every other input, including during an active handshake: Irq drops the next cycle.
- Overflow event, internal: ovf_evt = Valid & Overflow & (Sel==OP_ADD | Sel==OP_SUB). Overflow is ignored for non-arithmetic Sel.
- Flags, one-cycle latency:
  - On Valid: FlagZ/FlagN are loaded from Result.
  - FlagV <= ovf_evt. For a non-arithmetic Sel this gives FlagV=0.
  - With Valid=0, all three flags hold.
- StickyV: set on ovf_evt; cleared by StatClr. When StatClr and ovf_evt occur in the same cycle, the event wins: StickyV=1 and OvfCount=1.
- OvfCount:
  - Increments by 1 on ovf_evt.
  - Saturates at 2^CNT_W-1 and never wraps.
  - StatClr loads 0, or 1 if ovf_evt occurs in the same cycle.
- Interrupt FSM, states IDLE, REQ, ACK:
  - IDLE -> REQ when ovf_evt & IrqEn. Irq=1 from the following cycle.
  - REQ -> ACK when IrqAck=1. Irq drops the cycle after the transition.
  - ACK -> IDLE when IrqAck=0.
  - An ovf_evt arriving in REQ or ACK sets Missed=1 and does not queue a second request.
  - IrqEn falling while in REQ does not withdraw the request; the handshake must complete.
  - IrqAck asserted in IDLE is ignored.
  - Irq = (state==REQ), registered.
- Missed: cleared only by StatClr or Reset. Same-cycle rule as StickyV: a new event during REQ/ACK in the StatClr cycle leaves Missed=1.
- Back-to-back Valid every cycle is supported with no stalls.

Decomposition:
- Shared package alu_pkg:
  - OP_ADD=3'b000 and OP_SUB=3'b001, shared with the ALU select logic.
  - IRQ_IDLE/IRQ_REQ/IRQ_ACK state encodings as a 2-bit typedef.
- One sub-module, sat_counter: parameter W; inputs Clk, Reset, Clr, Inc; output Count. Implements the clear-with-simultaneous-increment rule.

Test Plan:
- Reset then Valid, Sel=000, Overflow=1, Result=8'h80 -> next cycle FlagV=1, FlagN=1, FlagZ=0, StickyV=1, OvfCount=1.
- Valid, Sel=011, Overflow=1, Result=8'h00 -> FlagV=0, FlagZ=1, StickyV unchanged, OvfCount unchanged, Irq stays 0.
- 20 consecutive sub overflows with CNT_W=4 -> OvfCount holds at 4'hF. Then StatClr alone -> OvfCount=0 and StickyV=0. Then StatClr with an overflow in the same cycle -> OvfCount=1 and StickyV=1.
- IrqEn=1, add overflow -> Irq=1 the following cycle. A second overflow while in REQ -> Missed=1 and Irq stays high. IrqAck=1 -> Irq=0. IrqAck=0 -> IDLE. A new overflow -> Irq=1 again.
- IrqEn=0 with an overflow -> Irq stays 0 and StickyV=1. IrqEn dropped during REQ -> Irq remains 1 until IrqAck.
- Reset asserted while in REQ with Irq=1 -> next cycle Irq=0, all flags, OvfCount and Missed=0, FSM in IDLE. IrqAck held high afterwards -> no effect.
